fetch_queue: RTL

//  Instruction fetch queue between the PC/IM fetch stage and the decode stage.

---
 rtl/fetch_queue.sv | 78 +++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch stage and decode.
// Buffers {pc, instr} pairs so a decode stall does not immediately freeze the
// PC. A flush (redirect resolved in decode) discards every buffered entry.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               drop all entries; same-cycle push/pop are ignored
//   in_valid/in_ready   fetch-side handshake carrying in_pc/in_instr
//   out_valid/out_ready decode-side handshake; out_pc/out_instr show the head
//   count               number of valid entries (0..DEPTH)
module fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2,
  parameter logic [31:0] NOP_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Handshake status derives from the registered count alone (no full bypass).
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != CNT_W'(0));

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Show-ahead head; empty queue presents a NOP at the reset PC.
  assign out_pc    = out_valid ? mem[rd_ptr].pc    : NOP_PC;
  assign out_instr = out_valid ? mem[rd_ptr].instr : 32'h0000_0000;

  // Storage is never cleared; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end
  end

  // Pointer and occupancy update: reset > flush > push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
